// File: rtl/srt4_post_processing_if.sv
// Handshake and data bundle between the SRT-4 iteration core and the post-processing back end.
// The slave modport is the post-processing block; the master side feeds results and consumes outputs.
interface srt4_post_processing_if #(
    parameter int DW = 32,
    parameter int QW = DW + 2
);
    logic            in_valid;
    logic            in_ready;
    logic [QW-1:0]   q_pos;
    logic [QW-1:0]   q_neg;
    logic [DW+5:0]   rem_star;
    logic [DW+2:0]   divisor_star;
    logic [DW/2-1:0] recovery;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            div_zero;

    modport master (
        output in_valid, q_pos, q_neg, rem_star, divisor_star, recovery, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, q_pos, q_neg, rem_star, divisor_star, recovery, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/srt4_post_processing.sv
// SRT-4 divider back end: redundant-to-binary quotient conversion, negative remainder
// correction and one-bit-per-cycle remainder de-normalisation behind a valid/ready handshake.
module srt4_post_processing #(
    parameter int DW = 32,
    parameter int QW = DW + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    srt4_post_processing_if.slave bus
);
    localparam int RW  = DW + 6;
    localparam int DSW = DW + 3;
    localparam int CW  = $clog2(DW) + 1;

    typedef enum logic [2:0] {IDLE, CONV, CORR, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   q_q, q_d;
    logic [QW-1:0]   q_neg_q, q_neg_d;
    logic [RW-1:0]   rem_star_q, rem_star_d;
    logic [DSW-1:0]  divisor_star_q, divisor_star_d;
    logic [DSW-1:0]  rem_q, rem_d;
    logic [CW-1:0]   lz_q, lz_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   quotient_q, quotient_d;
    logic [DW-1:0]   remainder_q, remainder_d;
    logic            div_zero_q, div_zero_d;

    logic            rem_neg;
    logic [RW-1:0]   rem_sum;
    logic [QW-1:0]   q_corr;
    logic [DSW-1:0]  rem_corr;
    logic [DSW-1:0]  rem_shift;
    logic            unused_rem_sum_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            q_q            <= '0;
            q_neg_q        <= '0;
            rem_star_q     <= '0;
            divisor_star_q <= '0;
            rem_q          <= '0;
            lz_q           <= '0;
            cnt_q          <= '0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            div_zero_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            q_q            <= q_d;
            q_neg_q        <= q_neg_d;
            rem_star_q     <= rem_star_d;
            divisor_star_q <= divisor_star_d;
            rem_q          <= rem_d;
            lz_q           <= lz_d;
            cnt_q          <= cnt_d;
            quotient_q     <= quotient_d;
            remainder_q    <= remainder_d;
            div_zero_q     <= div_zero_d;
        end
    end

    // A negative final remainder means the last digit overshot: add one divisor back, drop one from Q.
    always_comb begin
        rem_neg           = rem_star_q[RW-1];
        rem_sum           = rem_star_q + {{(RW-DSW){divisor_star_q[DSW-1]}}, divisor_star_q};
        q_corr            = rem_neg ? (q_q - QW'(1)) : q_q;
        rem_corr          = rem_neg ? rem_sum[DSW-1:0] : rem_star_q[DSW-1:0];
        rem_shift         = rem_q >> 1;
        unused_rem_sum_hi = ^rem_sum[RW-1:DSW];
    end

    always_comb begin
        state_d        = state_q;
        q_d            = q_q;
        q_neg_d        = q_neg_q;
        rem_star_d     = rem_star_q;
        divisor_star_d = divisor_star_q;
        rem_d          = rem_q;
        lz_d           = lz_q;
        cnt_d          = cnt_q;
        quotient_d     = quotient_q;
        remainder_d    = remainder_q;
        div_zero_d     = div_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.recovery == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = '0;
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d        = CONV;
                        div_zero_d     = 1'b0;
                        q_d            = bus.q_pos;
                        q_neg_d        = bus.q_neg;
                        rem_star_d     = bus.rem_star;
                        divisor_star_d = bus.divisor_star;
                        lz_d           = CW'(DW) - CW'(bus.recovery);
                    end
                end
            end
            CONV: begin
                q_d     = q_q - q_neg_q;
                state_d = CORR;
            end
            CORR: begin
                q_d   = q_corr;
                rem_d = rem_corr;
                if (lz_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = q_corr[DW-1:0];
                    remainder_d = rem_corr[DW-1:0];
                end else begin
                    state_d = SHIFT;
                    cnt_d   = lz_q;
                end
            end
            SHIFT: begin
                rem_d = rem_shift;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = q_q[DW-1:0];
                    remainder_d = rem_shift[DW-1:0];
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.quotient  = quotient_q;
        bus.remainder = remainder_q;
        bus.div_zero  = div_zero_q;
    end
endmodule
